// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial transmitter that frames each accepted word behind a fixed preamble
//
// Ports:
//   clk        in   1       single clock, all state updates on posedge
//   rst        in   1       synchronous active-high reset
//   din        in   DATA_W  payload word, captured only on an accept edge
//   din_valid  in   1       producer offers din
//   din_ready  out  1       transmitter idle and out of reset (combinational)
//   dout       out  1       registered serial line, idles high
//   busy       out  1       a frame is in progress (combinational)
//   frame_done out  1       registered one-cycle pulse when a frame completes
//   ps         out  3       current state: IDLE=0 PRE=1 DATA=2 GAP=3
module seq_pattern_tx #(
    parameter int               DATA_W  = 8,
    parameter int               PRE_W   = 4,
    parameter logic [PRE_W-1:0] PRE     = 4'b0110,
    parameter int               GAP_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout,
    output logic              busy,
    output logic              frame_done,
    output logic [2:0]        ps
);

    localparam int MAX_PD = (PRE_W > DATA_W) ? PRE_W : DATA_W;
    localparam int MAX_W  = (MAX_PD > GAP_CYC) ? MAX_PD : GAP_CYC;
    localparam int CNT_W  = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_GAP  = 3'd3
    } state_t;

    state_t            st, st_n;
    logic [CNT_W-1:0]  cnt, cnt_n, cnt_m1;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              dout_n, fd_n;
    logic              pre_bit, sh_bit;

    assign ps        = st;
    assign busy      = (st != S_IDLE);
    assign din_ready = (st == S_IDLE) && !rst;
    assign cnt_m1    = cnt - 1'b1;

    // Bit selection by mask keeps the index width independent of the vector widths.
    assign pre_bit = |(PRE & (PRE_W'(1) << cnt_m1));
    assign sh_bit  = |(shreg & (DATA_W'(1) << cnt_m1));

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_IDLE;
            cnt        <= '0;
            shreg      <= '0;
            dout       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            st         <= st_n;
            cnt        <= cnt_n;
            shreg      <= shreg_n;
            dout       <= dout_n;
            frame_done <= fd_n;
        end
    end

    always_comb begin
        st_n    = st;
        cnt_n   = cnt;
        shreg_n = shreg;
        dout_n  = 1'b1;
        fd_n    = 1'b0;
        case (st)
            S_IDLE: begin
                if (din_valid) begin
                    st_n    = S_PRE;
                    cnt_n   = CNT_W'(PRE_W - 1);
                    shreg_n = din;
                    dout_n  = PRE[PRE_W-1];
                end
            end
            S_PRE: begin
                if (cnt != '0) begin
                    cnt_n  = cnt_m1;
                    dout_n = pre_bit;
                end else begin
                    st_n   = S_DATA;
                    cnt_n  = CNT_W'(DATA_W - 1);
                    dout_n = shreg[DATA_W-1];
                end
            end
            S_DATA: begin
                if (cnt != '0) begin
                    cnt_n  = cnt_m1;
                    dout_n = sh_bit;
                end else begin
                    st_n   = S_GAP;
                    cnt_n  = CNT_W'(GAP_CYC - 1);
                end
            end
            S_GAP: begin
                if (cnt != '0) begin
                    cnt_n = cnt_m1;
                end else begin
                    st_n = S_IDLE;
                    fd_n = 1'b1;
                end
            end
            default: begin
                st_n  = S_IDLE;
                cnt_n = '0;
            end
        endcase
    end

endmodule
